// File: rtl/quick_spi_sequencer.sv
// quick_spi_sequencer: queues SPI read/write commands and issues them one at
// a time to an SPI master, returning read data and flagging stalled transfers.
module quick_spi_sequencer #(
    parameter int INCOMING_DATA_WIDTH   = 8,
    parameter int OUTGOING_DATA_WIDTH   = 16,
    parameter int NUMBER_OF_SLAVES      = 2,
    parameter int CMD_FIFO_DEPTH        = 4,
    parameter int INTER_TRANSACTION_GAP = 2,
    parameter int TIMEOUT_CYCLES        = 1024
) (
    input  logic                           clk,
    input  logic                           reset,

    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_operation,
    input  logic [NUMBER_OF_SLAVES-1:0]    cmd_slave,
    input  logic [OUTGOING_DATA_WIDTH-1:0] cmd_data,

    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [INCOMING_DATA_WIDTH-1:0] rsp_data,
    output logic [NUMBER_OF_SLAVES-1:0]    rsp_slave,

    output logic                           spi_enable,
    output logic                           spi_start_transaction,
    output logic                           spi_operation,
    output logic [NUMBER_OF_SLAVES-1:0]    spi_slave,
    output logic [OUTGOING_DATA_WIDTH-1:0] spi_outgoing_data,
    input  logic                           spi_end_of_transaction,
    input  logic [INCOMING_DATA_WIDTH-1:0] spi_incoming_data,

    output logic                           busy,
    output logic                           timeout_error,
    input  logic                           error_clear
);

    localparam int PTR_W = $clog2(CMD_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = $clog2(INTER_TRANSACTION_GAP + 1);
    localparam int CMD_W = 1 + NUMBER_OF_SLAVES + OUTGOING_DATA_WIDTH;

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(CMD_FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(INTER_TRANSACTION_GAP - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EOT,
        RESPOND,
        GAP
    } state_t;

    state_t state;
    state_t state_d;

    logic [CMD_W-1:0]               fifo_mem [CMD_FIFO_DEPTH];
    logic [PTR_W-1:0]               wr_ptr;
    logic [PTR_W-1:0]               rd_ptr;
    logic [CNT_W-1:0]               fifo_count;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic                           push;
    logic                           pop;

    logic [CMD_W-1:0]               head;
    logic                           head_operation;
    logic [NUMBER_OF_SLAVES-1:0]    head_slave;
    logic [OUTGOING_DATA_WIDTH-1:0] head_data;

    logic [TMR_W-1:0]               timer;
    logic [GAP_W-1:0]               gap_count;

    logic [INCOMING_DATA_WIDTH-1:0] cap_data;
    logic [NUMBER_OF_SLAVES-1:0]    cap_slave;

    logic                           capture;
    logic                           load_rsp;
    logic                           timeout_hit;

    assign fifo_full  = (fifo_count == FULL_COUNT);
    assign fifo_empty = (fifo_count == '0);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign busy       = (state != IDLE) || !fifo_empty;

    assign head = fifo_mem[rd_ptr];
    assign {head_operation, head_slave, head_data} = head;

    // Command FIFO pointers and occupancy; a push and a pop may share a cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Command storage; entries are only read after they have been written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_operation, cmd_slave, cmd_data};
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and per-cycle strobes; end of transaction beats timeout.
    always_comb begin
        state_d     = state;
        pop         = 1'b0;
        capture     = 1'b0;
        load_rsp    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = WAIT_EOT;
                end
            end
            WAIT_EOT: begin
                if (spi_end_of_transaction) begin
                    capture = !spi_operation;
                    state_d = spi_operation ? GAP : RESPOND;
                end else if (timer == TMR_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = GAP;
                end
            end
            RESPOND: begin
                if (!rsp_valid || rsp_ready) begin
                    load_rsp = 1'b1;
                    state_d  = GAP;
                end
            end
            GAP: begin
                if (gap_count == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Timeout counter restarts with each issue; gap counter runs only in GAP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer     <= '0;
            gap_count <= '0;
        end else begin
            if (pop) begin
                timer <= '0;
            end else if (state == WAIT_EOT) begin
                timer <= timer + 1'b1;
            end
            if (state != GAP) begin
                gap_count <= '0;
            end else begin
                gap_count <= gap_count + 1'b1;
            end
        end
    end

    // Drive the SPI master; the command fields hold until the next issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spi_enable            <= 1'b0;
            spi_start_transaction <= 1'b0;
            spi_operation         <= 1'b0;
            spi_slave             <= '0;
            spi_outgoing_data     <= '0;
        end else begin
            spi_enable            <= 1'b1;
            spi_start_transaction <= pop;
            if (pop) begin
                spi_operation     <= head_operation;
                spi_slave         <= head_slave;
                spi_outgoing_data <= head_data;
            end
        end
    end

    // Hold read data from the end-of-transaction cycle until it can be sent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_data  <= '0;
            cap_slave <= '0;
        end else if (capture) begin
            cap_data  <= spi_incoming_data;
            cap_slave <= spi_slave;
        end
    end

    // Response register; a fresh load on a handshake keeps rsp_valid high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_slave <= '0;
        end else if (load_rsp) begin
            rsp_valid <= 1'b1;
            rsp_data  <= cap_data;
            rsp_slave <= cap_slave;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Sticky timeout flag; a new timeout overrides a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_error <= 1'b0;
        end else if (timeout_hit) begin
            timeout_error <= 1'b1;
        end else if (error_clear) begin
            timeout_error <= 1'b0;
        end
    end

endmodule
